// File: rtl/rf_power_meter.sv
// rf_power_meter
//   Downstream stage of the RF gain block. Forwards the 16-lane signed 16-bit
//   sample stream through a single register slice. Over a programmed window of
//   accepted beats it measures the peak |sample|, the sum of squares and the
//   number of clipped samples. The result is returned on a valid/ready port.
//
//   Build option: RF_POWER_METER_CLIP_EN
//     defined   - clip comparators and the res_clips counter are built
//     undefined - no clip logic, res_clips is tied to 0 (port list unchanged)
//
// Ports
//   aclk, areset              clock, asynchronous active-high reset
//   rf_in_*  / rf_out_*       AXI-stream style sample input / forwarded output
//   cfg_window_beats          beats per measurement, sampled on cfg_start
//   cfg_start                 one-cycle pulse that arms a measurement
//   busy                      measurement in progress (ACCUM or DRAIN)
//   res_peak/energy/clips     measurement result
//   res_valid, res_ready      result handshake
//
// state  | meaning
// IDLE   | waiting for cfg_start with a non-zero window
// ACCUM  | counting measured beats down to zero
// DRAIN  | two cycles for the S1/S2 pipeline to fold the last beat
// HOLD   | result valid and frozen until res_ready
module rf_power_meter #(
  parameter int          LANES       = 16,
  parameter logic [15:0] CLIP_THRESH = 16'h7FFF,
  parameter int          WIN_W       = 16
) (
  input  logic                  aclk,
  input  logic                  areset,
  input  logic [16*LANES-1:0]   rf_in_tdata,
  input  logic                  rf_in_tvalid,
  output logic                  rf_in_tready,
  output logic [16*LANES-1:0]   rf_out_tdata,
  output logic                  rf_out_tvalid,
  input  logic                  rf_out_tready,
  input  logic [WIN_W-1:0]      cfg_window_beats,
  input  logic                  cfg_start,
  output logic                  busy,
  output logic [15:0]           res_peak,
  output logic [WIN_W+33:0]     res_energy,
  output logic [WIN_W+4:0]      res_clips,
  output logic                  res_valid,
  input  logic                  res_ready
);

  localparam int SUM_W = 31 + $clog2(LANES);
  localparam int CNT_W = $clog2(LANES + 1);
  localparam int EN_W  = WIN_W + 34;
  localparam int CL_W  = WIN_W + 5;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_DRAIN = 2'd2,
    S_HOLD  = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [WIN_W-1:0]   remaining_q, remaining_d;
  logic               drain_q, drain_d;

  logic               out_valid_q;
  logic [16*LANES-1:0] out_data_q;

  logic               in_beat;
  logic               measure;
  logic               acc_clr;

  // ---------------- pass-through slice ----------------
  assign rf_in_tready  = !out_valid_q || rf_out_tready;
  assign rf_out_tvalid = out_valid_q;
  assign rf_out_tdata  = out_data_q;
  assign in_beat       = rf_in_tvalid && rf_in_tready;

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else if (rf_in_tready) begin
      out_valid_q <= rf_in_tvalid;
      if (rf_in_tvalid) out_data_q <= rf_in_tdata;
    end
  end

  // ---------------- S1: per-lane abs and square ----------------
  logic [15:0] lane_abs [LANES];
  logic [30:0] lane_sq  [LANES];
  logic [15:0] s1_abs_q [LANES];
  logic [30:0] s1_sq_q  [LANES];
  logic        s1_valid_q;

  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      // modulo-2^16 negation yields 0x8000 for -32768, the correct magnitude
      lane_abs[i] = rf_in_tdata[16*i+15] ? (16'd0 - rf_in_tdata[16*i +: 16])
                                         : rf_in_tdata[16*i +: 16];
      // |x|^2 <= 2^30, so a 31-bit product is exact
      lane_sq[i]  = {15'd0, lane_abs[i]} * {15'd0, lane_abs[i]};
    end
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      s1_valid_q <= 1'b0;
      for (int i = 0; i < LANES; i++) begin
        s1_abs_q[i] <= '0;
        s1_sq_q[i]  <= '0;
      end
    end else begin
      s1_valid_q <= measure;
      if (measure) begin
        for (int i = 0; i < LANES; i++) begin
          s1_abs_q[i] <= lane_abs[i];
          s1_sq_q[i]  <= lane_sq[i];
        end
      end
    end
  end

  // ---------------- S2: per-beat reduction and accumulation ----------------
  logic [15:0]      beat_max;
  logic [SUM_W-1:0] beat_sum;
  logic [15:0]      peak_q;
  logic [EN_W-1:0]  energy_q;

  always_comb begin
    beat_max = '0;
    beat_sum = '0;
    for (int i = 0; i < LANES; i++) begin
      if (s1_abs_q[i] > beat_max) beat_max = s1_abs_q[i];
      beat_sum = beat_sum + SUM_W'(s1_sq_q[i]);
    end
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      peak_q   <= '0;
      energy_q <= '0;
    end else if (acc_clr) begin
      peak_q   <= '0;
      energy_q <= '0;
    end else if (s1_valid_q) begin
      if (beat_max > peak_q) peak_q <= beat_max;
      energy_q <= energy_q + EN_W'(beat_sum);
    end
  end

  assign res_peak   = peak_q;
  assign res_energy = energy_q;

`ifdef RF_POWER_METER_CLIP_EN
  logic [CNT_W-1:0] beat_clips;
  logic [CL_W-1:0]  clips_q;

  always_comb begin
    beat_clips = '0;
    for (int i = 0; i < LANES; i++) begin
      if (s1_abs_q[i] >= CLIP_THRESH) beat_clips = beat_clips + CNT_W'(1);
    end
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      clips_q <= '0;
    end else if (acc_clr) begin
      clips_q <= '0;
    end else if (s1_valid_q) begin
      clips_q <= clips_q + CL_W'(beat_clips);
    end
  end

  assign res_clips = clips_q;
`else
  assign res_clips = '0;
`endif

  // ---------------- FSM: state register ----------------
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_q     <= S_IDLE;
      remaining_q <= '0;
      drain_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      drain_q     <= drain_d;
    end
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    drain_d     = drain_q;
    case (state_q)
      S_IDLE: begin
        if (cfg_start && (cfg_window_beats != '0)) begin
          state_d     = S_ACCUM;
          remaining_d = cfg_window_beats;
        end
      end
      S_ACCUM: begin
        if (in_beat) begin
          remaining_d = remaining_q - WIN_W'(1);
          if (remaining_q == WIN_W'(1)) begin
            state_d = S_DRAIN;
            drain_d = 1'b1;
          end
        end
      end
      S_DRAIN: begin
        // last beat reaches S1 on entry and the accumulators one cycle later
        if (drain_q == 1'b0) state_d = S_HOLD;
        else                 drain_d = 1'b0;
      end
      S_HOLD: begin
        if (res_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    busy      = (state_q == S_ACCUM) || (state_q == S_DRAIN);
    res_valid = (state_q == S_HOLD);
    measure   = in_beat && (state_q == S_ACCUM);
    acc_clr   = (state_q == S_IDLE) && cfg_start && (cfg_window_beats != '0);
  end

endmodule

// File: tb/tb_rf_power_meter.sv
// Directed bench for rf_power_meter: reset, pass-through with and without
// back-pressure, measurement results, result hold, zero window and reset
// in the middle of a window.
module tb_rf_power_meter;

  logic         aclk;
  logic         areset;
  logic [255:0] rf_in_tdata;
  logic         rf_in_tvalid;
  logic         rf_in_tready;
  logic [255:0] rf_out_tdata;
  logic         rf_out_tvalid;
  logic         rf_out_tready;
  logic [15:0]  cfg_window_beats;
  logic         cfg_start;
  logic         busy;
  logic [15:0]  res_peak;
  logic [49:0]  res_energy;
  logic [20:0]  res_clips;
  logic         res_valid;
  logic         res_ready;

  int checks = 0;
  int errors = 0;

`ifdef RF_POWER_METER_CLIP_EN
  localparam logic [20:0] CLIPS_MIX = 21'd4;
  localparam logic [20:0] CLIPS_MAX = 21'd16;
`else
  localparam logic [20:0] CLIPS_MIX = 21'd0;
  localparam logic [20:0] CLIPS_MAX = 21'd0;
`endif
  localparam logic [49:0] ENERGY_MIX = 50'd4362116164;
  localparam logic [49:0] ENERGY_MAX = 50'd17178820624;

  rf_power_meter dut (
    .aclk             (aclk),
    .areset           (areset),
    .rf_in_tdata      (rf_in_tdata),
    .rf_in_tvalid     (rf_in_tvalid),
    .rf_in_tready     (rf_in_tready),
    .rf_out_tdata     (rf_out_tdata),
    .rf_out_tvalid    (rf_out_tvalid),
    .rf_out_tready    (rf_out_tready),
    .cfg_window_beats (cfg_window_beats),
    .cfg_start        (cfg_start),
    .busy             (busy),
    .res_peak         (res_peak),
    .res_energy       (res_energy),
    .res_clips        (res_clips),
    .res_valid        (res_valid),
    .res_ready        (res_ready)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // The mixed pattern {0x0064,0x1000,0x8000,0xFFFF} placed at lanes rot..rot+3
  // (mod 16): every beat has the same statistics but distinct data.
  function automatic logic [255:0] mk_beat(input int rot);
    logic [255:0] b;
    b = '0;
    b[16*((rot + 0) % 16) +: 16] = 16'h0064;
    b[16*((rot + 1) % 16) +: 16] = 16'h1000;
    b[16*((rot + 2) % 16) +: 16] = 16'h8000;
    b[16*((rot + 3) % 16) +: 16] = 16'hFFFF;
    return b;
  endfunction

  task automatic wait_res(input int budget);
    int n;
    n = 0;
    while (res_valid !== 1'b1 && n < budget) begin
      @(negedge aclk);
      n++;
    end
    check("res_valid_wait", res_valid, 1);
  endtask

  task automatic start_window(input logic [15:0] w);
    cfg_window_beats = w;
    cfg_start = 1'b1;
    @(negedge aclk);
    cfg_start = 1'b0;
  endtask

  task automatic take_result();
    res_ready = 1'b1;
    @(negedge aclk);
    res_ready = 1'b0;
    check("res_valid_after_take", res_valid, 0);
  endtask

  initial begin
    logic [255:0] exp_q [$];
    int sent;
    int got;
    logic tog;
    logic in_hs;
    logic out_hs;

    rf_in_tdata = '0;
    rf_in_tvalid = 1'b0;
    rf_out_tready = 1'b1;
    cfg_window_beats = '0;
    cfg_start = 1'b0;
    res_ready = 1'b0;
    areset = 1'b0;
    #2 areset = 1'b1;

    // 1: reset held with toggling inputs
    for (int i = 0; i < 4; i++) begin
      @(negedge aclk);
      rf_in_tvalid = i[0];
      rf_in_tdata = mk_beat(i);
      cfg_window_beats = 16'd3;
      cfg_start = i[0];
      rf_out_tready = i[1];
      res_ready = i[0];
    end
    @(negedge aclk);
    check("rst_out_tvalid", rf_out_tvalid, 0);
    check("rst_out_tdata", rf_out_tdata, 0);
    check("rst_busy", busy, 0);
    check("rst_res_valid", res_valid, 0);
    check("rst_res_peak", res_peak, 0);
    check("rst_res_energy", res_energy, 0);
    check("rst_res_clips", res_clips, 0);
    areset = 1'b0;
    rf_in_tvalid = 1'b0;
    cfg_start = 1'b0;
    res_ready = 1'b0;
    rf_out_tready = 1'b0;
    @(negedge aclk);
    check("rel_in_tready", rf_in_tready, 1);
    check("rel_busy", busy, 0);
    rf_out_tready = 1'b1;

    // 2: window of 4 mixed beats at full throughput
    start_window(16'd4);
    check("t2_busy_armed", busy, 1);
    for (int k = 0; k < 4; k++) begin
      rf_in_tvalid = 1'b1;
      rf_in_tdata = mk_beat(k);
      @(negedge aclk);
      check("t2_out_tvalid", rf_out_tvalid, 1);
      check("t2_out_tdata", rf_out_tdata, mk_beat(k));
    end
    rf_in_tvalid = 1'b0;
    check("t2_res_valid_c1", res_valid, 0);
    check("t2_busy_c1", busy, 1);
    @(negedge aclk);
    check("t2_res_valid_c2", res_valid, 0);
    @(negedge aclk);
    check("t2_res_valid_c3", res_valid, 1);
    check("t2_busy_hold", busy, 0);
    check("t2_peak", res_peak, 16'h8000);
    check("t2_energy", res_energy, ENERGY_MIX);
    check("t2_clips", res_clips, CLIPS_MIX);

    // 4: result not taken for 10 cycles, start pulse ignored
    for (int c = 0; c < 10; c++) begin
      cfg_window_beats = 16'd2;
      cfg_start = (c == 3);
      @(negedge aclk);
      check("t4_res_valid", res_valid, 1);
      check("t4_peak", res_peak, 16'h8000);
      check("t4_energy", res_energy, ENERGY_MIX);
      check("t4_clips", res_clips, CLIPS_MIX);
      check("t4_busy", busy, 0);
    end
    cfg_start = 1'b0;
    take_result();
    check("t4_busy_idle", busy, 0);

    // 3: same statistics with rf_out_tready toggling 1010..
    start_window(16'd4);
    sent = 0;
    got = 0;
    tog = 1'b1;
    for (int cyc = 0; cyc < 60 && (sent < 4 || got < 4); cyc++) begin
      rf_out_tready = tog;
      tog = !tog;
      rf_in_tvalid = (sent < 4);
      rf_in_tdata = mk_beat(sent + 5);
      #1;
      in_hs = rf_in_tvalid && rf_in_tready;
      out_hs = rf_out_tvalid && rf_out_tready;
      if (out_hs) begin
        if (exp_q.size() == 0) begin
          check("t3_unexpected_beat", rf_out_tdata, 0);
        end else begin
          check("t3_out_tdata", rf_out_tdata, exp_q[0]);
          void'(exp_q.pop_front());
        end
        got++;
      end
      if (in_hs) begin
        exp_q.push_back(rf_in_tdata);
        sent++;
      end
      @(negedge aclk);
    end
    rf_in_tvalid = 1'b0;
    rf_out_tready = 1'b1;
    check("t3_sent", sent, 4);
    check("t3_got", got, 4);
    #1;
    check("t3_out_empty", rf_out_tvalid, 0);
    wait_res(10);
    check("t3_peak", res_peak, 16'h8000);
    check("t3_energy", res_energy, ENERGY_MIX);
    check("t3_clips", res_clips, CLIPS_MIX);
    @(negedge aclk);
    take_result();

    // 5: zero window is ignored
    start_window(16'd0);
    check("t5_busy", busy, 0);
    for (int c = 0; c < 5; c++) begin
      @(negedge aclk);
      check("t5_res_valid", res_valid, 0);
    end
    check("t5_busy_end", busy, 0);

    // 6: reset after 2 of 4 beats, then a fresh 1-beat window of 0x7FFF
    start_window(16'd4);
    for (int k = 0; k < 2; k++) begin
      rf_in_tvalid = 1'b1;
      rf_in_tdata = mk_beat(k);
      @(negedge aclk);
    end
    rf_in_tvalid = 1'b0;
    areset = 1'b1;
    #1;
    check("t6_res_valid", res_valid, 0);
    check("t6_busy", busy, 0);
    check("t6_out_tvalid", rf_out_tvalid, 0);
    check("t6_energy", res_energy, 0);
    @(negedge aclk);
    areset = 1'b0;
    @(negedge aclk);
    start_window(16'd1);
    rf_in_tvalid = 1'b1;
    rf_in_tdata = {16{16'h7FFF}};
    @(negedge aclk);
    rf_in_tvalid = 1'b0;
    check("t6_busy_drain", busy, 1);
    wait_res(6);
    check("t6_peak", res_peak, 16'h7FFF);
    check("t6_energy_max", res_energy, ENERGY_MAX);
    check("t6_clips", res_clips, CLIPS_MAX);
    take_result();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
